uart_frame_assembler: RTL and testbench

- Sits between the 115200-baud UART receiver and the first fully-connected layer.
- Turns the raw received byte stream into a validated 64-byte input vector.
- Frame format: sync byte, payload, checksum. Hunts for sync, collects payload, verifies checksum, enforces an inter-byte timeout.
- Presents the vector with a valid/ack handshake, so the FC pipeline never sees a partial or corrupt image.

---
 rtl/uart_frame_assembler_pkg.sv | 33 +++
 rtl/uart_frame_assembler_idle_timer.sv | 30 +++
 rtl/uart_frame_assembler.sv | 137 +++++++++++++
 tb/tb_uart_frame_assembler.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_assembler_pkg.sv
// Shared constants and state encoding for the UART frame assembler.
package uart_frame_assembler_pkg;

    localparam int unsigned CLK_HZ             = 100_000_000;
    localparam int unsigned BAUD_RATE          = 115_200;
    // 1 ms of inter-byte silence at the system clock
    localparam int unsigned TIMEOUT_CYCLES_DEF = CLK_HZ / 1000;

    // Input-vector length shared with the first FC layer
    localparam int unsigned N_BYTES_FC         = 64;
    localparam logic [7:0]  SYNC_BYTE_DEF      = 8'hA5;
    localparam int unsigned CNT_W_DEF          = 8;

    // One-hot state encoding
    localparam int unsigned ST_W       = 4;
    localparam logic [ST_W-1:0] ST_HUNT    = 4'b0001;
    localparam logic [ST_W-1:0] ST_PAYLOAD = 4'b0010;
    localparam logic [ST_W-1:0] ST_CHECK   = 4'b0100;
    localparam logic [ST_W-1:0] ST_HOLD    = 4'b1000;

    typedef enum logic [ST_W-1:0] {
        HUNT    = ST_HUNT,
        PAYLOAD = ST_PAYLOAD,
        CHECK   = ST_CHECK,
        HOLD    = ST_HOLD
    } state_t;

    // Frame is good when payload sum plus checksum byte wraps to zero
    function automatic logic chk_ok(input logic [7:0] sum, input logic [7:0] chk);
        return 8'(sum + chk) == 8'h00;
    endfunction

endpackage

// File: rtl/uart_frame_assembler_idle_timer.sv
// Idle timer: counts enabled cycles since the last clear and flags the last allowed one.
module uart_frame_assembler_idle_timer
    import uart_frame_assembler_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] count;

    // Count up to LAST and hold there; expired is registered alongside the count
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count   <= '0;
            expired <= (LAST == '0);
        end else if (en && !expired) begin
            count   <= count + TMR_W'(1);
            expired <= (count + TMR_W'(1)) == LAST;
        end
    end

endmodule

// File: rtl/uart_frame_assembler.sv
// Assembles sync/payload/checksum UART frames into a validated input vector.
module uart_frame_assembler
    import uart_frame_assembler_pkg::*;
#(
    parameter int unsigned N_BYTES        = N_BYTES_FC,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    input  logic                 frame_ack,
    output logic [8*N_BYTES-1:0] frame_data,
    output logic                 frame_valid,
    output logic                 busy,
    output logic                 chk_err,
    output logic                 tmo_err,
    output logic [CNT_W-1:0]     chk_err_cnt,
    output logic [CNT_W-1:0]     tmo_err_cnt,
    output logic [CNT_W-1:0]     ovr_cnt
);

    localparam int unsigned IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [7:0]       sum;
    logic             in_frame;
    logic             tmr_clr;
    logic             tmr_en;
    logic             tmr_expired;

    // Timer runs only while a frame is open; any received byte restarts it
    assign in_frame = (state == PAYLOAD) || (state == CHECK);
    assign tmr_clr  = byte_valid || !in_frame;
    assign tmr_en   = !tmr_clr;

    uart_frame_assembler_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // Frame FSM with registered outputs, checksum accumulator and saturating counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            idx         <= '0;
            sum         <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            chk_err     <= 1'b0;
            tmo_err     <= 1'b0;
            chk_err_cnt <= '0;
            tmo_err_cnt <= '0;
            ovr_cnt     <= '0;
        end else begin
            chk_err <= 1'b0;
            tmo_err <= 1'b0;
            unique case (state)
                HUNT: begin
                    if (byte_valid && (byte_data == SYNC_BYTE)) begin
                        state <= PAYLOAD;
                        busy  <= 1'b1;
                        idx   <= '0;
                        sum   <= '0;
                    end
                end
                PAYLOAD: begin
                    // A sync value here is ordinary payload data
                    if (byte_valid) begin
                        frame_data[{idx, 3'b000} +: 8] <= byte_data;
                        sum <= sum + byte_data;
                        idx <= idx + IDX_W'(1);
                        if (idx == IDX_LAST) begin
                            state <= CHECK;
                        end
                    end else if (tmr_expired) begin
                        state   <= HUNT;
                        busy    <= 1'b0;
                        tmo_err <= 1'b1;
                        if (tmo_err_cnt != CNT_MAX) begin
                            tmo_err_cnt <= tmo_err_cnt + CNT_W'(1);
                        end
                    end
                end
                CHECK: begin
                    if (byte_valid) begin
                        busy <= 1'b0;
                        if (chk_ok(sum, byte_data)) begin
                            state       <= HOLD;
                            frame_valid <= 1'b1;
                        end else begin
                            state   <= HUNT;
                            chk_err <= 1'b1;
                            if (chk_err_cnt != CNT_MAX) begin
                                chk_err_cnt <= chk_err_cnt + CNT_W'(1);
                            end
                        end
                    end else if (tmr_expired) begin
                        state   <= HUNT;
                        busy    <= 1'b0;
                        tmo_err <= 1'b1;
                        if (tmo_err_cnt != CNT_MAX) begin
                            tmo_err_cnt <= tmo_err_cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // Bytes arriving while the buffer is owned by the consumer are lost
                    if (byte_valid && (ovr_cnt != CNT_MAX)) begin
                        ovr_cnt <= ovr_cnt + CNT_W'(1);
                    end
                    if (frame_ack) begin
                        state       <= HUNT;
                        frame_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= HUNT;
                    busy        <= 1'b0;
                    frame_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Self-checking bench for uart_frame_assembler with a frame-level reference model.
module tb_uart_frame_assembler;

    localparam int unsigned N    = 64;
    localparam int unsigned T    = 200;
    localparam int unsigned CW   = 8;
    localparam int          CMAX = (1 << CW) - 1;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic              clk;
    logic              rst;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              frame_ack;
    logic [8*N-1:0]    frame_data;
    logic              frame_valid;
    logic              busy;
    logic              chk_err;
    logic              tmo_err;
    logic [CW-1:0]     chk_err_cnt;
    logic [CW-1:0]     tmo_err_cnt;
    logic [CW-1:0]     ovr_cnt;

    int errors = 0;
    int checks = 0;
    int exp_chk = 0;
    int exp_tmo = 0;
    int exp_ovr = 0;

    logic [7:0] pl [N];

    uart_frame_assembler #(
        .N_BYTES        (N),
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .frame_ack   (frame_ack),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .busy        (busy),
        .chk_err     (chk_err),
        .tmo_err     (tmo_err),
        .chk_err_cnt (chk_err_cnt),
        .tmo_err_cnt (tmo_err_cnt),
        .ovr_cnt     (ovr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model helpers ----------------
    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    function automatic int pl_sum();
        int s = 0;
        for (int k = 0; k < N; k++) s += int'(pl[k]);
        return s;
    endfunction

    function automatic logic [7:0] good_chk();
        return 8'((256 - (pl_sum() % 256)) % 256);
    endfunction

    function automatic logic [8*N-1:0] pl_vec();
        logic [8*N-1:0] v;
        for (int k = 0; k < N; k++) v[8*k +: 8] = pl[k];
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++) pl[k] = 8'($urandom);
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < N; k++) pl[k] = 8'(k + 1);
    endtask

    task automatic send_payload(input int from, input int to);
        for (int k = from; k <= to; k++) send(pl[k]);
    endtask

    task automatic pulse_ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        byte_valid = 1'b1;
        byte_data  = SYNC;
        frame_ack  = 1'b1;
        tick();
        tick();
        byte_valid = 1'b0;
        frame_ack  = 1'b0;
        rst = 1'b0;
        checks++;
        if ({frame_valid, busy, chk_err, tmo_err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got v=%b b=%b c=%b t=%b want all 0", frame_valid, busy, chk_err, tmo_err);
        end
        checks++;
        if (frame_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", frame_data);
        end
        checks++;
        if ({chk_err_cnt, tmo_err_cnt, ovr_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_cnts: got %0d %0d %0d want 0 0 0", chk_err_cnt, tmo_err_cnt, ovr_cnt);
        end
    endtask

    task automatic test_garbage_before_sync();
        logic [7:0] junk [3];
        junk[0] = 8'h00; junk[1] = 8'hFF; junk[2] = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            send(junk[i]);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL garbage_busy[%0d]: got %b want 0", i, busy);
            end
        end
        fill_random();
        send(SYNC);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL sync_busy: got %b want 1", busy);
        end
        send_payload(0, N - 1);
        send(good_chk());
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== pl_vec()) begin
            errors++;
            $display("FAIL garbage_frame: got v=%b data=%h want v=1 data=%h", frame_valid, frame_data, pl_vec());
        end
        checks++;
        if ({chk_err_cnt, tmo_err_cnt, ovr_cnt} !== '0) begin
            errors++;
            $display("FAIL garbage_cnts: got %0d %0d %0d want 0 0 0", chk_err_cnt, tmo_err_cnt, ovr_cnt);
        end
        pulse_ack();
    endtask

    task automatic test_good_frame();
        fill_ramp();
        send(SYNC);
        send_payload(0, N - 1);
        checks++;
        if (frame_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL good_pre_chk: got v=%b busy=%b want v=0 busy=1", frame_valid, busy);
        end
        send(8'hE0);
        checks++;
        if (frame_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL good_valid: got v=%b busy=%b want v=1 busy=0", frame_valid, busy);
        end
        checks++;
        if (frame_data[7:0] !== 8'h01 || frame_data[8*63 +: 8] !== 8'h40) begin
            errors++;
            $display("FAIL good_ends: got b0=%h b63=%h want 01 40", frame_data[7:0], frame_data[8*63 +: 8]);
        end
        checks++;
        if (chk_err_cnt !== CW'(exp_chk)) begin
            errors++;
            $display("FAIL good_chkcnt: got %0d want %0d", chk_err_cnt, exp_chk);
        end
        pulse_ack();
        checks++;
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL good_ack: got v=%b want 0", frame_valid);
        end
    endtask

    task automatic test_sync_in_payload();
        fill_random();
        pl[5] = SYNC;
        send(SYNC);
        send_payload(0, 5);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL sync_payload_busy: got %b want 1", busy);
        end
        send_payload(6, N - 1);
        send(good_chk());
        checks++;
        if (frame_valid !== 1'b1 || frame_data[8*5 +: 8] !== SYNC || frame_data !== pl_vec()) begin
            errors++;
            $display("FAIL sync_payload_data: got v=%b b5=%h want v=1 b5=a5 full=%h", frame_valid, frame_data[8*5 +: 8], pl_vec());
        end
        pulse_ack();
    endtask

    task automatic test_bad_checksum();
        fill_ramp();
        send(SYNC);
        send_payload(0, N - 1);
        send(8'hE1);
        exp_chk = sat_inc(exp_chk);
        checks++;
        if (chk_err !== 1'b1 || chk_err_cnt !== CW'(exp_chk)) begin
            errors++;
            $display("FAIL bad_chk_pulse: got err=%b cnt=%0d want 1 %0d", chk_err, chk_err_cnt, exp_chk);
        end
        checks++;
        if (frame_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_chk_state: got v=%b busy=%b want 0 0", frame_valid, busy);
        end
        tick();
        checks++;
        if (chk_err !== 1'b0) begin
            errors++;
            $display("FAIL bad_chk_width: got %b want 0", chk_err);
        end
        fill_random();
        send(SYNC);
        send_payload(0, N - 1);
        send(good_chk());
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== pl_vec()) begin
            errors++;
            $display("FAIL bad_chk_recover: got v=%b data=%h want 1 %h", frame_valid, frame_data, pl_vec());
        end
        pulse_ack();
    endtask

    task automatic test_timeout();
        int  n;
        bit  found;
        bit  early;
        fill_random();
        send(SYNC);
        send_payload(0, 9);
        n = 0;
        found = 1'b0;
        while (n < 2 * T && !found) begin
            tick();
            n++;
            if (tmo_err === 1'b1) found = 1'b1;
        end
        exp_tmo = sat_inc(exp_tmo);
        checks++;
        if (!found || n != T) begin
            errors++;
            $display("FAIL tmo_latency: got found=%0d after %0d cycles want %0d", found, n, T);
        end
        checks++;
        if (tmo_err_cnt !== CW'(exp_tmo) || busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_cnt: got cnt=%0d busy=%b want %0d 0", tmo_err_cnt, busy, exp_tmo);
        end
        tick();
        checks++;
        if (tmo_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_width: got %b want 0", tmo_err);
        end
        // byte landing exactly on the expiry cycle wins
        fill_random();
        send(SYNC);
        send_payload(0, 9);
        early = 1'b0;
        for (int i = 0; i < T - 1; i++) begin
            tick();
            if (tmo_err !== 1'b0) early = 1'b1;
        end
        send(pl[10]);
        checks++;
        if (early || tmo_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL tmo_race: got early=%0d tmo=%b busy=%b want 0 0 1", early, tmo_err, busy);
        end
        send_payload(11, N - 1);
        send(good_chk());
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== pl_vec() || tmo_err_cnt !== CW'(exp_tmo)) begin
            errors++;
            $display("FAIL tmo_race_frame: got v=%b cnt=%0d data=%h want 1 %0d %h", frame_valid, tmo_err_cnt, frame_data, exp_tmo, pl_vec());
        end
        pulse_ack();
    endtask

    task automatic test_overrun();
        logic [8*N-1:0] held;
        fill_random();
        send(SYNC);
        send_payload(0, N - 1);
        send(good_chk());
        held = pl_vec();
        for (int i = 0; i < 3; i++) begin
            send(8'($urandom));
            exp_ovr = sat_inc(exp_ovr);
        end
        checks++;
        if (ovr_cnt !== CW'(exp_ovr) || frame_valid !== 1'b1 || frame_data !== held) begin
            errors++;
            $display("FAIL ovr_hold: got cnt=%0d v=%b data=%h want %0d 1 %h", ovr_cnt, frame_valid, frame_data, exp_ovr, held);
        end
        byte_valid = 1'b1;
        byte_data  = SYNC;
        frame_ack  = 1'b1;
        tick();
        byte_valid = 1'b0;
        frame_ack  = 1'b0;
        exp_ovr = sat_inc(exp_ovr);
        checks++;
        if (ovr_cnt !== CW'(exp_ovr) || frame_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ovr_collide: got cnt=%0d v=%b busy=%b want %0d 0 0", ovr_cnt, frame_valid, busy, exp_ovr);
        end
        // ack while assembling is ignored
        fill_random();
        send(SYNC);
        send_payload(0, 19);
        pulse_ack();
        send_payload(20, N - 1);
        send(good_chk());
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== pl_vec() || ovr_cnt !== CW'(exp_ovr)) begin
            errors++;
            $display("FAIL ack_ignored: got v=%b ovr=%0d data=%h want 1 %0d %h", frame_valid, ovr_cnt, frame_data, exp_ovr, pl_vec());
        end
        pulse_ack();
    endtask

    task automatic test_random_frames();
        logic [7:0] chk;
        logic [7:0] g;
        bit         ok;
        for (int f = 0; f < 30; f++) begin
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                g = 8'($urandom);
                if (g == SYNC) g = 8'h5A;
                send(g);
            end
            fill_random();
            chk = good_chk();
            if ($urandom_range(0, 2) == 0) chk = chk ^ 8'($urandom_range(1, 255));
            ok = ((pl_sum() + int'(chk)) % 256) == 0;
            send(SYNC);
            for (int k = 0; k < N; k++) begin
                send(pl[k]);
                if ($urandom_range(0, 3) == 0) begin
                    for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
                        frame_ack = 1'($urandom);
                        tick();
                    end
                    frame_ack = 1'b0;
                end
            end
            send(chk);
            if (!ok) exp_chk = sat_inc(exp_chk);
            checks++;
            if (frame_valid !== ok || chk_err !== !ok || chk_err_cnt !== CW'(exp_chk)) begin
                errors++;
                $display("FAIL rand_frame[%0d]: got v=%b err=%b cnt=%0d want %b %b %0d", f, frame_valid, chk_err, chk_err_cnt, ok, !ok, exp_chk);
            end
            if (ok) begin
                if ($urandom_range(0, 1) == 1) begin
                    send(8'($urandom));
                    exp_ovr = sat_inc(exp_ovr);
                end
                checks++;
                if (frame_data !== pl_vec() || ovr_cnt !== CW'(exp_ovr)) begin
                    errors++;
                    $display("FAIL rand_data[%0d]: got ovr=%0d data=%h want %0d %h", f, ovr_cnt, frame_data, exp_ovr, pl_vec());
                end
                pulse_ack();
                checks++;
                if (frame_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_ack[%0d]: got v=%b want 0", f, frame_valid);
                end
            end
        end
    endtask

    task automatic test_saturation();
        for (int f = 0; f < 260; f++) begin
            fill_random();
            send(SYNC);
            send_payload(0, N - 1);
            send(good_chk() + 8'd1);
            exp_chk = sat_inc(exp_chk);
        end
        checks++;
        if (chk_err_cnt !== CW'(exp_chk) || chk_err !== 1'b1) begin
            errors++;
            $display("FAIL saturation: got cnt=%0d err=%b want %0d 1", chk_err_cnt, chk_err, exp_chk);
        end
    endtask

    task automatic test_reset_mid_payload();
        fill_random();
        send(SYNC);
        send_payload(0, 6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_chk = 0;
        exp_tmo = 0;
        exp_ovr = 0;
        checks++;
        if (frame_data !== '0 || {frame_valid, busy, chk_err, tmo_err} !== 4'b0) begin
            errors++;
            $display("FAIL rst_mid_out: got v=%b busy=%b data=%h want all 0", frame_valid, busy, frame_data);
        end
        checks++;
        if ({chk_err_cnt, tmo_err_cnt, ovr_cnt} !== '0) begin
            errors++;
            $display("FAIL rst_mid_cnts: got %0d %0d %0d want 0 0 0", chk_err_cnt, tmo_err_cnt, ovr_cnt);
        end
        fill_random();
        send(SYNC);
        send_payload(0, N - 1);
        send(good_chk());
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== pl_vec() || chk_err_cnt !== CW'(exp_chk)) begin
            errors++;
            $display("FAIL rst_mid_fresh: got v=%b cnt=%0d data=%h want 1 %0d %h", frame_valid, chk_err_cnt, frame_data, exp_chk, pl_vec());
        end
        pulse_ack();
    endtask

    initial begin
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        frame_ack  = 1'b0;
        test_reset();
        test_garbage_before_sync();
        test_good_frame();
        test_sync_in_payload();
        test_bad_checksum();
        test_timeout();
        test_overrun();
        test_random_frames();
        test_saturation();
        test_reset_mid_payload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
